matrix_mult_nxn: RTL and testbench

Parametrised successor to the team's fixed 3x3, 8-bit two-stage matrix multiplier. Computes C = A x B for square N x N matrices of DW-bit elements, with selectable signed/unsigned arithmetic and saturating or truncating output formatting. Operands are accepted and results delivered over valid/ready handshakes, so the block can sit between a matrix source and a consumer that may apply backpressure. Per-matrix overflow is reported.

---
 rtl/matrix_mult_nxn.sv | 173 +++++++++++++++++
 tb/tb_matrix_mult_nxn.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/matrix_mult_nxn.sv
// -----------------------------------------------------------------------------
// matrix_mult_nxn
//   Computes C = A x B for square N x N matrices of DW-bit elements.
//   Operands arrive on a valid/ready input port; the formatted result leaves on
//   a valid/ready output port. One k-step of the dot products is done per cycle
//   with N*N parallel multipliers, so a matrix takes N MAC cycles plus one
//   formatting cycle.
//
//   Handshake: a transfer happens on a rising edge where valid and ready are
//   both high. in_ready depends only on the state register. Once out_valid is
//   raised, c_flat/ovf/out_valid hold until out_ready is seen high.
//
// Ports
//   clk        : clock, rising edge
//   rst_n      : synchronous active-low reset
//   in_valid   : A/B operands valid
//   in_ready   : block is idle and will take operands
//   a_flat     : A, row-major, element (i,k) at [(i*N+k)*DW +: DW]
//   b_flat     : B, same packing
//   out_valid  : c_flat/ovf valid
//   out_ready  : consumer takes the result
//   c_flat     : C, row-major, element (i,j) at [(i*N+j)*OW +: OW]
//   ovf        : at least one element of C fell outside the OW range
//   busy       : block is not idle
// -----------------------------------------------------------------------------
module matrix_mult_nxn #(
    parameter int N      = 3,
    parameter int DW     = 8,
    parameter int OW     = 8,
    parameter int SIGNED = 0,
    parameter int SAT    = 0
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [N*N*DW-1:0]   a_flat,
    input  logic [N*N*DW-1:0]   b_flat,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [N*N*OW-1:0]   c_flat,
    output logic                ovf,
    output logic                busy
);

    localparam int AW = 2*DW + $clog2(N);
    localparam int KW = $clog2(N);
    localparam int NE = N*N;

    typedef enum logic [1:0] {S_IDLE, S_MAC, S_FMT, S_OUT} state_t;

    state_t              state_q, state_d;
    logic [KW-1:0]       k_q;
    logic [NE*DW-1:0]    a_q, b_q;
    logic [AW-1:0]       acc_q [NE];
    logic [AW-1:0]       prod [NE];
    logic [OW-1:0]       fmt_val [NE];
    logic                elem_ovf [NE];
    logic                any_ovf;
    logic [NE*OW-1:0]    c_q;
    logic                ovf_q;

    // ---------------- FSM ----------------
    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d   = state_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b1;
        case (state_q)
            S_IDLE: begin
                in_ready = 1'b1;
                busy     = 1'b0;
                if (in_valid) state_d = S_MAC;
            end
            S_MAC:   if (k_q == KW'(N-1)) state_d = S_FMT;
            S_FMT:   state_d = S_OUT;
            S_OUT: begin
                out_valid = 1'b1;
                if (out_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // ---------------- per-element products and output formatting ----------------
    for (genvar e = 0; e < NE; e++) begin : g_elem
        localparam int I = e / N;
        localparam int J = e % N;

        logic [DW-1:0] a_e, b_e;
        logic [AW-1:0] a_x, b_x;
        logic [OW-1:0] bound;

        assign a_e = a_q[(I*N + int'(k_q))*DW +: DW];
        assign b_e = b_q[(int'(k_q)*N + J)*DW +: DW];

        if (SIGNED != 0) begin : g_sx
            assign a_x = {{(AW-DW){a_e[DW-1]}}, a_e};
            assign b_x = {{(AW-DW){b_e[DW-1]}}, b_e};
        end else begin : g_zx
            assign a_x = {{(AW-DW){1'b0}}, a_e};
            assign b_x = {{(AW-DW){1'b0}}, b_e};
        end

        // AW > 2*DW, so the low AW bits of the extended product are exact
        // in both signed and unsigned modes.
        assign prod[e] = a_x * b_x;

        if (OW < AW) begin : g_narrow
            if (SIGNED != 0) begin : g_s
                localparam logic [OW-1:0] SMIN = OW'(1) << (OW-1);
                localparam logic [OW-1:0] SMAX = ~SMIN;
                logic [AW-OW:0] top;
                // In range iff every bit from the OW sign bit upward matches.
                assign top         = acc_q[e][AW-1:OW-1];
                assign elem_ovf[e] = !((&top) || !(|top));
                assign bound       = acc_q[e][AW-1] ? SMIN : SMAX;
            end else begin : g_u
                assign elem_ovf[e] = |acc_q[e][AW-1:OW];
                assign bound       = '1;
            end
            assign fmt_val[e] = ((SAT != 0) && elem_ovf[e]) ? bound : acc_q[e][OW-1:0];
        end else begin : g_full
            assign elem_ovf[e] = 1'b0;
            assign bound       = '0;
            assign fmt_val[e]  = acc_q[e][OW-1:0] | bound;
        end
    end

    always_comb begin
        any_ovf = 1'b0;
        for (int e = 0; e < NE; e++) any_ovf = any_ovf | elem_ovf[e];
    end

    // ---------------- datapath registers ----------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            k_q   <= '0;
            a_q   <= '0;
            b_q   <= '0;
            c_q   <= '0;
            ovf_q <= 1'b0;
            for (int e = 0; e < NE; e++) acc_q[e] <= '0;
        end else begin
            case (state_q)
                S_IDLE: if (in_valid) begin
                    a_q <= a_flat;
                    b_q <= b_flat;
                    k_q <= '0;
                    for (int e = 0; e < NE; e++) acc_q[e] <= '0;
                end
                S_MAC: begin
                    for (int e = 0; e < NE; e++) acc_q[e] <= acc_q[e] + prod[e];
                    k_q <= (k_q == KW'(N-1)) ? '0 : k_q + 1'b1;
                end
                S_FMT: begin
                    for (int e = 0; e < NE; e++) c_q[e*OW +: OW] <= fmt_val[e];
                    ovf_q <= any_ovf;
                end
                default: ;
            endcase
        end
    end

    assign c_flat = c_q;
    assign ovf    = ovf_q;

endmodule

// File: tb/tb_matrix_mult_nxn.sv
// -----------------------------------------------------------------------------
// tb_matrix_mult_nxn
//   Directed bench for matrix_mult_nxn. Five instances cover the parameter
//   sets: u0 N=3 unsigned wrap, u1 N=3 unsigned saturate, u2 N=3 signed
//   saturate, u3 N=4 DW=4 OW=10, u4 N=4 DW=4 OW=9. Expected values are
//   hand-computed constants.
// -----------------------------------------------------------------------------
module tb_matrix_mult_nxn;

    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_fail;

    // u0..u2: N=3, DW=8, OW=8
    logic        in_valid0, in_ready0, out_valid0, out_ready0, ovf0, busy0;
    logic [71:0] a0, b0, c0;
    logic        in_valid1, in_ready1, out_valid1, out_ready1, ovf1, busy1;
    logic [71:0] a1, b1, c1;
    logic        in_valid2, in_ready2, out_valid2, out_ready2, ovf2, busy2;
    logic [71:0] a2, b2, c2;
    // u3/u4: N=4, DW=4, OW=10 / 9
    logic         in_valid3, in_ready3, out_valid3, out_ready3, ovf3, busy3;
    logic [63:0]  a3, b3;
    logic [159:0] c3;
    logic         in_valid4, in_ready4, out_valid4, out_ready4, ovf4, busy4;
    logic [63:0]  a4, b4;
    logic [143:0] c4;

    matrix_mult_nxn #(.N(3), .DW(8), .OW(8), .SIGNED(0), .SAT(0)) u0 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid0), .in_ready(in_ready0),
        .a_flat(a0), .b_flat(b0), .out_valid(out_valid0), .out_ready(out_ready0),
        .c_flat(c0), .ovf(ovf0), .busy(busy0));
    matrix_mult_nxn #(.N(3), .DW(8), .OW(8), .SIGNED(0), .SAT(1)) u1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid1), .in_ready(in_ready1),
        .a_flat(a1), .b_flat(b1), .out_valid(out_valid1), .out_ready(out_ready1),
        .c_flat(c1), .ovf(ovf1), .busy(busy1));
    matrix_mult_nxn #(.N(3), .DW(8), .OW(8), .SIGNED(1), .SAT(1)) u2 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid2), .in_ready(in_ready2),
        .a_flat(a2), .b_flat(b2), .out_valid(out_valid2), .out_ready(out_ready2),
        .c_flat(c2), .ovf(ovf2), .busy(busy2));
    matrix_mult_nxn #(.N(4), .DW(4), .OW(10), .SIGNED(0), .SAT(0)) u3 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid3), .in_ready(in_ready3),
        .a_flat(a3), .b_flat(b3), .out_valid(out_valid3), .out_ready(out_ready3),
        .c_flat(c3), .ovf(ovf3), .busy(busy3));
    matrix_mult_nxn #(.N(4), .DW(4), .OW(9), .SIGNED(0), .SAT(0)) u4 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid4), .in_ready(in_ready4),
        .a_flat(a4), .b_flat(b4), .out_valid(out_valid4), .out_ready(out_ready4),
        .c_flat(c4), .ovf(ovf4), .busy(busy4));

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Cycles from the accept edge until out_valid of the chosen instance
    // (0 -> u0, 1 -> u1, 3 -> u3); bounded at 20.
    task automatic wait_out(input int which, output int cnt);
        logic ov;
        cnt = 0;
        ov  = 1'b0;
        while (!ov && cnt < 20) begin
            tick();
            cnt++;
            case (which)
                0:       ov = out_valid0;
                1:       ov = out_valid1;
                default: ov = out_valid3;
            endcase
        end
    endtask

    task automatic set_identity0();
        for (int i = 0; i < 3; i++)
            for (int k = 0; k < 3; k++) begin
                a0[(i*3+k)*8 +: 8] = (i == k) ? 8'd1 : 8'd0;
                b0[(i*3+k)*8 +: 8] = 8'(i*3 + k + 1);
            end
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int lat;
        n_cmp  = 0;
        n_fail = 0;
        rst_n  = 1'b0;
        {in_valid0, in_valid1, in_valid2, in_valid3, in_valid4} = '0;
        {out_ready0, out_ready1, out_ready2, out_ready3, out_ready4} = '0;
        a0 = '0; b0 = '0; a1 = '0; b1 = '0; a2 = '0; b2 = '0;
        a3 = '0; b3 = '0; a4 = '0; b4 = '0;
        repeat (2) tick();
        rst_n = 1'b1;

        // Reset state
        check("rst_in_ready", in_ready0, 1);
        check("rst_out_valid", out_valid0, 0);
        check("rst_busy", busy0, 0);
        check("rst_c_flat_any", |c0, 0);
        check("rst_ovf", ovf0, 0);

        // Identity: A = I, B = 1..9
        set_identity0();
        in_valid0 = 1'b1;
        tick();
        in_valid0 = 1'b0;
        check("id_busy_after_accept", busy0, 1);
        check("id_in_ready_after_accept", in_ready0, 0);
        wait_out(0, lat);
        check("id_latency", lat, 4);
        for (int e = 0; e < 9; e++) check("id_c", c0[e*8 +: 8], e + 1);
        check("id_ovf", ovf0, 0);

        // Backpressure: out_ready low 5 cycles, second in_valid with new data
        a0 = '1;
        b0 = '1;
        in_valid0 = 1'b1;
        for (int cyc = 0; cyc < 5; cyc++) begin
            tick();
            check("bp_out_valid", out_valid0, 1);
            check("bp_in_ready", in_ready0, 0);
            check("bp_ovf", ovf0, 0);
            for (int e = 0; e < 9; e++) check("bp_c", c0[e*8 +: 8], e + 1);
        end
        in_valid0  = 1'b0;
        out_ready0 = 1'b1;
        tick();
        out_ready0 = 1'b0;
        check("hs_out_valid", out_valid0, 0);
        check("hs_in_ready", in_ready0, 1);
        check("hs_busy", busy0, 0);
        tick();
        check("hs_no_stray_accept", busy0, 0);
        check("hs_c_retained", c0[7:0], 1);

        // Unsigned wrap: all 255 -> 195075 mod 256 = 3
        in_valid0 = 1'b1;
        tick();
        in_valid0 = 1'b0;
        wait_out(0, lat);
        check("wrap_latency", lat, 4);
        for (int e = 0; e < 9; e++) check("wrap_c", c0[e*8 +: 8], 3);
        check("wrap_ovf", ovf0, 1);
        out_ready0 = 1'b1;
        tick();
        out_ready0 = 1'b0;

        // Unsigned clamp (u1) and signed clamp (u2) side by side
        a1 = '1;
        b1 = '1;
        a2 = {9{8'h80}};
        b2 = {9{8'h7F}};
        in_valid1 = 1'b1;
        in_valid2 = 1'b1;
        tick();
        in_valid1 = 1'b0;
        in_valid2 = 1'b0;
        wait_out(1, lat);
        check("sat_latency", lat, 4);
        check("ssat_out_valid", out_valid2, 1);
        for (int e = 0; e < 9; e++) check("usat_c", c1[e*8 +: 8], 8'hFF);
        for (int e = 0; e < 9; e++) check("ssat_c", c2[e*8 +: 8], 8'h80);
        check("usat_ovf", ovf1, 1);
        check("ssat_ovf", ovf2, 1);
        out_ready1 = 1'b1;
        out_ready2 = 1'b1;
        tick();
        out_ready1 = 1'b0;
        out_ready2 = 1'b0;
        check("sat_hs_u1", out_valid1, 0);
        check("sat_hs_u2", out_valid2, 0);

        // N=4, DW=4: all 15 -> 900 (OW=10), 388 with ovf (OW=9)
        a3 = '1; b3 = '1; a4 = '1; b4 = '1;
        in_valid3 = 1'b1;
        in_valid4 = 1'b1;
        tick();
        in_valid3 = 1'b0;
        in_valid4 = 1'b0;
        wait_out(3, lat);
        check("n4_latency", lat, 5);
        check("n4_ow9_out_valid", out_valid4, 1);
        for (int e = 0; e < 16; e++) check("n4_ow10_c", c3[e*10 +: 10], 900);
        for (int e = 0; e < 16; e++) check("n4_ow9_c", c4[e*9 +: 9], 388);
        check("n4_ow10_ovf", ovf3, 0);
        check("n4_ow9_ovf", ovf4, 1);
        out_ready3 = 1'b1;
        out_ready4 = 1'b1;
        tick();
        out_ready3 = 1'b0;
        out_ready4 = 1'b0;

        // Reset during MAC with k = 1
        set_identity0();
        in_valid0 = 1'b1;
        tick();
        in_valid0 = 1'b0;
        tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("mrst_out_valid", out_valid0, 0);
        check("mrst_c_flat_any", |c0, 0);
        check("mrst_ovf", ovf0, 0);
        check("mrst_busy", busy0, 0);
        check("mrst_in_ready", in_ready0, 1);
        tick();
        check("mrst_no_output", out_valid0, 0);

        // Fresh identity after reset
        in_valid0 = 1'b1;
        tick();
        in_valid0 = 1'b0;
        wait_out(0, lat);
        check("id2_latency", lat, 4);
        for (int e = 0; e < 9; e++) check("id2_c", c0[e*8 +: 8], e + 1);
        check("id2_ovf", ovf0, 0);
        out_ready0 = 1'b1;
        tick();
        out_ready0 = 1'b0;
        check("id2_hs_in_ready", in_ready0, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
